mem_stage_ctrl: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS pipeline.
- Turns lw/sw control into a req/ack transaction on a variable-latency data-memory port, and stalls the pipeline until the access completes.
- Drives the MEM/WB register. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mem_stage_ctrl_if.sv | 22 ++
 rtl/mem_wb_pipe.sv | 46 ++++
 rtl/mem_stage_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS MEM-stage controller.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/acknowledge port between the MEM stage and a variable-latency data memory.
interface mem_stage_ctrl_if;
    import mips_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register; bubble clears the write-back controls, load takes the M-side values.
module mem_wb_pipe
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic              rd_load_i,
    input  logic              reg_write_i,
    input  logic              memto_reg_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [REG_W-1:0]  write_reg_i,
    input  logic [DATA_W-1:0] read_data_i,
    output logic              reg_write_o,
    output logic              memto_reg_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [REG_W-1:0]  write_reg_o,
    output logic [DATA_W-1:0] read_data_o
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_o <= 1'b0;
            memto_reg_o <= 1'b0;
            alu_out_o   <= '0;
            write_reg_o <= '0;
            read_data_o <= '0;
        end else begin
            if (bubble_i) begin
                reg_write_o <= 1'b0;
                memto_reg_o <= 1'b0;
            end else if (load_i) begin
                reg_write_o <= reg_write_i;
                memto_reg_o <= memto_reg_i;
                alu_out_o   <= alu_out_i;
                write_reg_o <= write_reg_i;
            end
            if (rd_load_i) begin
                read_data_o <= read_data_i;
            end
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns lw/sw into a req/ack memory access and stalls the pipeline until done.
// Optional access timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RegWriteM,
    input  logic                    MemtoRegM,
    input  logic                    MemWriteM,
    input  logic [DATA_W-1:0]       ALUOutM,
    input  logic [DATA_W-1:0]       WriteDataM,
    input  logic [REG_W-1:0]        WriteRegM,
    output logic                    StallM,
    mem_stage_ctrl_if.master        mem,
    output logic                    RegWriteW,
    output logic                    MemtoRegW,
    output logic [DATA_W-1:0]       ReadDataW,
    output logic [DATA_W-1:0]       ALUOutW,
    output logic [REG_W-1:0]        WriteRegW,
    output logic                    mem_err
);

    // The timeout counter is 8 bits wide, so the limit must fit in 1..255.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    mem_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              wb_load, wb_bubble, wb_rd_load;
    logic              timeout_hit;
    logic              memop;

    assign memop = MemtoRegM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       mem_err_q;

    assign timeout_hit = (state_q == ACCESS) && (cnt_q == TO_LAST);
    assign mem_err     = mem_err_q;

    // Held at zero outside ACCESS, so every access starts counting from a clean count.
    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_q | (timeout_hit & ~mem.mem_ack);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            buf_q   <= buf_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        buf_d      = buf_q;
        StallM     = 1'b0;
        wb_load    = 1'b0;
        wb_bubble  = 1'b0;
        wb_rd_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop) begin
                    StallM    = 1'b1;
                    wb_bubble = 1'b1;
                    addr_d    = ALUOutM;
                    wdata_d   = WriteDataM;
                    we_d      = MemWriteM;
                    state_d   = ACCESS;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ACCESS: begin
                StallM    = 1'b1;
                wb_bubble = 1'b1;
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        buf_d = mem.mem_rdata;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    buf_d   = ERR_DATA;
                    state_d = DONE;
                end
            end
            DONE: begin
                // EX/MEM still shows this instruction; returning to IDLE without a
                // memop check is what keeps it from being issued twice.
                wb_load    = 1'b1;
                wb_rd_load = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    mem_wb_pipe u_mem_wb_pipe (
        .clk         (clk),
        .rst         (rst),
        .load_i      (wb_load),
        .bubble_i    (wb_bubble),
        .rd_load_i   (wb_rd_load),
        .reg_write_i (RegWriteM),
        .memto_reg_i (MemtoRegM),
        .alu_out_i   (ALUOutM),
        .write_reg_i (WriteRegM),
        .read_data_i (buf_q),
        .reg_write_o (RegWriteW),
        .memto_reg_o (MemtoRegW),
        .alu_out_o   (ALUOutW),
        .write_reg_o (WriteRegW),
        .read_data_o (ReadDataW)
    );

endmodule
